// File: rtl/vtage_update_ctrl.sv
// Training controller for one vtage_bank: buffers committed outcomes, looks each up
// through the feedback port, issues registered update strobes, and runs useful-bit sweeps.
module vtage_update_ctrl #(
    parameter int P_NUM_PRED    = 2,
    parameter int P_NUM_ENTRIES = 256,
    parameter int P_TAG_WIDTH   = 8,
    parameter int P_FIFO_DEPTH  = 8,
    parameter int P_FAIL_THR    = 16,
    localparam int LP_INDEX_WIDTH = $clog2(P_NUM_ENTRIES)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [P_NUM_PRED-1:0]                         cm_valid_i,
    input  logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]     cm_index_i,
    input  logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]        cm_tag_i,
    input  logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]     cm_pred_value_i,
    input  logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]     cm_actual_value_i,
    output logic                                          cm_ready_o,
    output logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]     fb_index_o,
    output logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]        fb_tag_o,
    input  logic [P_NUM_PRED-1:0]                         fb_tag_match_i,
    input  logic [P_NUM_PRED-1:0]                         fb_alloc_avail_i,
    output logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]     ud_index_o,
    output logic [P_NUM_PRED-1:0]                         ud_incr_conf_o,
    output logic [P_NUM_PRED-1:0]                         ud_rst_conf_o,
    output logic [P_NUM_PRED-1:0]                         ud_incr_use_o,
    output logic [P_NUM_PRED-1:0]                         ud_decr_use_o,
    output logic [P_NUM_PRED-1:0]                         ud_rst_use_o,
    output logic [P_NUM_PRED-1:0]                         ud_load_tag_o,
    output logic [P_NUM_PRED-1:0]                         ud_load_value_o,
    output logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]        ud_tag_o,
    output logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]     ud_value_o,
    output logic                                          busy_o
);

    localparam int LP_PTR_W  = $clog2(P_FIFO_DEPTH);
    localparam int LP_CNT_W  = LP_PTR_W + 1;
    localparam int LP_FAIL_W = $clog2(P_FAIL_THR + 1);
    localparam logic [LP_INDEX_WIDTH-1:0] LP_LAST_BASE = LP_INDEX_WIDTH'(P_NUM_ENTRIES - P_NUM_PRED);

    typedef struct packed {
        logic [LP_INDEX_WIDTH-1:0] index;
        logic [P_TAG_WIDTH-1:0]    tag;
        logic [LP_INDEX_WIDTH-1:0] pred;
        logic [LP_INDEX_WIDTH-1:0] act;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_SWEEP} state_t;

    state_t                    state_q;
    logic [LP_PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LP_CNT_W-1:0]       count_q;
    logic [LP_FAIL_W-1:0]      fail_q;
    logic [LP_INDEX_WIDTH-1:0] sweep_base_q;
    req_t                      fifo_mem [P_FIFO_DEPTH];

    logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0] ud_index_q, ud_value_q;
    logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]    ud_tag_q;
    logic [P_NUM_PRED-1:0] incr_conf_q, rst_conf_q, incr_use_q, decr_use_q;
    logic [P_NUM_PRED-1:0] rst_use_q, load_tag_q, load_value_q;

    req_t                head;
    logic [LP_PTR_W-1:0] wr_addr [P_NUM_PRED];
    logic [LP_CNT_W-1:0] push_cnt;
    logic                lane0_pending, hazard, pop, hit, avail, correct;
    logic                unused_fb;

    assign cm_ready_o = (count_q <= LP_CNT_W'(P_FIFO_DEPTH - P_NUM_PRED));
    assign head       = fifo_mem[rd_ptr_q];
    assign hit        = fb_tag_match_i[0];
    assign avail      = fb_alloc_avail_i[0];
    assign correct    = (head.pred == head.act);
    assign unused_fb  = ^{fb_tag_match_i, fb_alloc_avail_i};

    // Any lane-0 strobe still on the update port means the bank has not yet absorbed that write.
    assign lane0_pending = incr_conf_q[0] | rst_conf_q[0] | incr_use_q[0] | decr_use_q[0]
                         | rst_use_q[0] | load_tag_q[0] | load_value_q[0];
    assign hazard = lane0_pending && (ud_index_q[0] == head.index);
    assign pop    = (state_q != S_SWEEP) && (count_q != '0) && !hazard;
    assign busy_o = (count_q != '0) || (state_q != S_IDLE);

    // Valid lanes are packed into consecutive slots in lane order.
    always_comb begin
        push_cnt = '0;
        for (int l = 0; l < P_NUM_PRED; l++) begin
            wr_addr[l] = wr_ptr_q + push_cnt[LP_PTR_W-1:0];
            if (cm_ready_o && cm_valid_i[l]) push_cnt = push_cnt + LP_CNT_W'(1);
        end
    end

    always_comb begin
        fb_index_o = '0;
        fb_tag_o   = '0;
        if (count_q != '0) begin
            fb_index_o[0] = head.index;
            fb_tag_o[0]   = head.tag;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int l = 0; l < P_NUM_PRED; l++) begin
            if (cm_ready_o && cm_valid_i[l])
                fifo_mem[wr_addr[l]] <= {cm_index_i[l], cm_tag_i[l], cm_pred_value_i[l], cm_actual_value_i[l]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fail_q       <= '0;
            sweep_base_q <= '0;
            ud_index_q   <= '0;
            ud_tag_q     <= '0;
            ud_value_q   <= '0;
            incr_conf_q  <= '0;
            rst_conf_q   <= '0;
            incr_use_q   <= '0;
            decr_use_q   <= '0;
            rst_use_q    <= '0;
            load_tag_q   <= '0;
            load_value_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + push_cnt[LP_PTR_W-1:0];
            if (pop) rd_ptr_q <= rd_ptr_q + LP_PTR_W'(1);
            count_q <= count_q + push_cnt - LP_CNT_W'(pop);

            ud_index_q   <= '0;
            ud_tag_q     <= '0;
            ud_value_q   <= '0;
            incr_conf_q  <= '0;
            rst_conf_q   <= '0;
            incr_use_q   <= '0;
            decr_use_q   <= '0;
            rst_use_q    <= '0;
            load_tag_q   <= '0;
            load_value_q <= '0;

            case (state_q)
                S_IDLE, S_UPDATE: begin
                    state_q <= S_IDLE;
                    if (pop) begin
                        state_q       <= S_UPDATE;
                        ud_index_q[0] <= head.index;
                        if (hit) begin
                            if (correct) begin
                                incr_conf_q[0] <= 1'b1;
                                incr_use_q[0]  <= 1'b1;
                            end else begin
                                rst_conf_q[0]   <= 1'b1;
                                decr_use_q[0]   <= 1'b1;
                                load_value_q[0] <= 1'b1;
                                ud_value_q[0]   <= head.act;
                            end
                        end else if (avail) begin
                            load_tag_q[0]   <= 1'b1;
                            load_value_q[0] <= 1'b1;
                            rst_conf_q[0]   <= 1'b1;
                            rst_use_q[0]    <= 1'b1;
                            ud_tag_q[0]     <= head.tag;
                            ud_value_q[0]   <= head.act;
                        end else begin
                            decr_use_q[0] <= 1'b1;
                            if (fail_q >= LP_FAIL_W'(P_FAIL_THR - 1)) begin
                                fail_q  <= LP_FAIL_W'(P_FAIL_THR);
                                state_q <= S_SWEEP;
                            end else begin
                                fail_q <= fail_q + LP_FAIL_W'(1);
                            end
                        end
                    end
                end
                S_SWEEP: begin
                    for (int l = 0; l < P_NUM_PRED; l++) begin
                        rst_use_q[l]  <= 1'b1;
                        ud_index_q[l] <= sweep_base_q + LP_INDEX_WIDTH'(l);
                    end
                    if (sweep_base_q == LP_LAST_BASE) begin
                        sweep_base_q <= '0;
                        fail_q       <= '0;
                        state_q      <= S_IDLE;
                    end else begin
                        sweep_base_q <= sweep_base_q + LP_INDEX_WIDTH'(P_NUM_PRED);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ud_index_o      = ud_index_q;
    assign ud_tag_o        = ud_tag_q;
    assign ud_value_o      = ud_value_q;
    assign ud_incr_conf_o  = incr_conf_q;
    assign ud_rst_conf_o   = rst_conf_q;
    assign ud_incr_use_o   = incr_use_q;
    assign ud_decr_use_o   = decr_use_q;
    assign ud_rst_use_o    = rst_use_q;
    assign ud_load_tag_o   = load_tag_q;
    assign ud_load_value_o = load_value_q;

endmodule

// File: tb/tb_vtage_update_ctrl.sv
// Bench for vtage_update_ctrl: directed vector table, hand-timed corner sequences and a
// randomized run checked against an ordered list of expected update-port events.
module tb_vtage_update_ctrl;
    localparam int NP = 2, NE = 256, TW = 8, IW = 8, THR = 16, OW = 62;
    localparam logic [6:0] S_HIT_OK  = 7'b1010000;  // incr_conf, incr_use
    localparam logic [6:0] S_HIT_BAD = 7'b0101001;  // rst_conf, decr_use, load_value
    localparam logic [6:0] S_ALLOC   = 7'b0100111;  // rst_conf, rst_use, load_tag, load_value
    localparam logic [6:0] S_NOALLOC = 7'b0001000;  // decr_use

    logic clk_i = 1'b0;
    logic rst_i;
    logic [NP-1:0] cm_valid_i;
    logic [NP-1:0][IW-1:0] cm_index_i, cm_pred_value_i, cm_actual_value_i;
    logic [NP-1:0][TW-1:0] cm_tag_i;
    logic cm_ready_o, busy_o;
    logic [NP-1:0][IW-1:0] fb_index_o, ud_index_o, ud_value_o;
    logic [NP-1:0][TW-1:0] fb_tag_o, ud_tag_o;
    logic [NP-1:0] fb_tag_match_i, fb_alloc_avail_i;
    logic [NP-1:0] ud_incr_conf_o, ud_rst_conf_o, ud_incr_use_o, ud_decr_use_o;
    logic [NP-1:0] ud_rst_use_o, ud_load_tag_o, ud_load_value_o;

    logic [TW-1:0] tag_tbl [NE];
    logic          avail_tbl [NE];

    // Bank stand-in: static tag/allocatable tables looked up combinationally.
    assign fb_tag_match_i   = {1'b0, tag_tbl[fb_index_o[0]] == fb_tag_o[0]};
    assign fb_alloc_avail_i = {1'b0, avail_tbl[fb_index_o[0]]};

    vtage_update_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cm_valid_i(cm_valid_i), .cm_index_i(cm_index_i), .cm_tag_i(cm_tag_i),
        .cm_pred_value_i(cm_pred_value_i), .cm_actual_value_i(cm_actual_value_i),
        .cm_ready_o(cm_ready_o),
        .fb_index_o(fb_index_o), .fb_tag_o(fb_tag_o),
        .fb_tag_match_i(fb_tag_match_i), .fb_alloc_avail_i(fb_alloc_avail_i),
        .ud_index_o(ud_index_o), .ud_incr_conf_o(ud_incr_conf_o), .ud_rst_conf_o(ud_rst_conf_o),
        .ud_incr_use_o(ud_incr_use_o), .ud_decr_use_o(ud_decr_use_o), .ud_rst_use_o(ud_rst_use_o),
        .ud_load_tag_o(ud_load_tag_o), .ud_load_value_o(ud_load_value_o),
        .ud_tag_o(ud_tag_o), .ud_value_o(ud_value_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0, n_fail = 0;
    logic [OW-1:0] exp_q[$];
    bit mon_en = 1'b0;
    int ref_fail = 0;

    typedef struct {
        logic [7:0] idx, tag, pred, act;
        logic       hit, avail;
        logic [6:0] strb;
        logic [7:0] etag, eval;
    } vec_t;
    vec_t vecs [9];

    function automatic logic [6:0] st(int l);
        return {ud_incr_conf_o[l], ud_rst_conf_o[l], ud_incr_use_o[l], ud_decr_use_o[l],
                ud_rst_use_o[l], ud_load_tag_o[l], ud_load_value_o[l]};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {ud_index_o, st(1), st(0), ud_tag_o, ud_value_o};
    endfunction

    function automatic logic any_strobe();
        return |{ud_incr_conf_o, ud_rst_conf_o, ud_incr_use_o, ud_decr_use_o,
                 ud_rst_use_o, ud_load_tag_o, ud_load_value_o};
    endfunction

    function automatic logic [OW-1:0] upd_rec(logic [7:0] idx, logic [6:0] s, logic [7:0] tag, logic [7:0] val);
        return {8'h00, idx, 7'h00, s, 8'h00, tag, 8'h00, val};
    endfunction

    function automatic logic [OW-1:0] sweep_rec(logic [7:0] base);
        logic [7:0] b1;
        b1 = base + 8'd1;
        return {b1, base, 7'b0000100, 7'b0000100, 32'h0};
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference: outcome of one commit from the bank tables, plus a full sweep after every THR-th failure.
    task automatic model_commit(input logic [7:0] idx, tag, pred, act);
        if (tag_tbl[idx] == tag) begin
            exp_q.push_back((pred == act) ? upd_rec(idx, S_HIT_OK, 8'h00, 8'h00)
                                          : upd_rec(idx, S_HIT_BAD, 8'h00, act));
        end else if (avail_tbl[idx]) begin
            exp_q.push_back(upd_rec(idx, S_ALLOC, tag, act));
        end else begin
            exp_q.push_back(upd_rec(idx, S_NOALLOC, 8'h00, 8'h00));
            ref_fail++;
            if (ref_fail == THR) begin
                for (int b = 0; b < NE; b += NP) exp_q.push_back(sweep_rec(8'(b)));
                ref_fail = 0;
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (mon_en && !rst_i) begin
            if (any_strobe()) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got %h expected none", obs());
                end else begin
                    check("scoreboard", obs(), exp_q.pop_front());
                end
            end else begin
                check("idle_outputs", obs(), '0);
            end
        end
    end

    task automatic push_req(input logic [1:0] v, input logic [1:0][7:0] idx, tag, pred, act);
        int t;
        t = 0;
        @(negedge clk_i);
        while (!cm_ready_o && t < 400) begin
            @(negedge clk_i);
            t++;
        end
        check1("push_ready", cm_ready_o, 1'b1);
        if (cm_ready_o) begin
            cm_valid_i = v;
            cm_index_i = idx;
            cm_tag_i = tag;
            cm_pred_value_i = pred;
            cm_actual_value_i = act;
            for (int l = 0; l < NP; l++)
                if (v[l]) model_commit(idx[l], tag[l], pred[l], act[l]);
            @(posedge clk_i);
            #1 cm_valid_i = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        cm_valid_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic drain(input int limit);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy_o) && t < limit) begin
            @(negedge clk_i);
            t++;
        end
        @(negedge clk_i);
        check("drain_queue", OW'(exp_q.size()), '0);
        check1("drain_idle", busy_o, 1'b0);
    endtask

    initial begin
        int t, stray;
        logic [1:0][7:0] ix, tg, pr, ac;
        for (int i = 0; i < NE; i++) begin
            tag_tbl[i] = 8'h00;
            avail_tbl[i] = 1'b0;
        end
        rst_i = 1'b1;
        cm_valid_i = '0;
        cm_index_i = '0;
        cm_tag_i = '0;
        cm_pred_value_i = '0;
        cm_actual_value_i = '0;
        #12;
        check("reset_outputs", obs(), '0);
        check1("reset_ready", cm_ready_o, 1'b1);
        check1("reset_busy", busy_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;

        vecs[0] = '{8'd5,   8'h3A, 8'd7,  8'd7,  1'b1, 1'b0, S_HIT_OK,  8'h00, 8'h00};
        vecs[1] = '{8'd9,   8'h11, 8'd0,  8'h42, 1'b0, 1'b1, S_ALLOC,   8'h11, 8'h42};
        vecs[2] = '{8'd20,  8'h55, 8'd3,  8'd4,  1'b1, 1'b1, S_HIT_BAD, 8'h00, 8'h04};
        vecs[3] = '{8'd255, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, S_HIT_OK,  8'h00, 8'h00};
        vecs[4] = '{8'd0,   8'h00, 8'h00, 8'h80, 1'b1, 1'b0, S_HIT_BAD, 8'h00, 8'h80};
        vecs[5] = '{8'd77,  8'h12, 8'h01, 8'h01, 1'b0, 1'b1, S_ALLOC,   8'h12, 8'h01};
        vecs[6] = '{8'd100, 8'h01, 8'h09, 8'h09, 1'b0, 1'b0, S_NOALLOC, 8'h00, 8'h00};
        vecs[7] = '{8'd33,  8'h44, 8'h01, 8'h81, 1'b1, 1'b0, S_HIT_BAD, 8'h00, 8'h81};
        vecs[8] = '{8'd128, 8'hC3, 8'h10, 8'h20, 1'b0, 1'b1, S_ALLOC,   8'hC3, 8'h20};

        // Single lane-0 commits: strobe exactly one cycle after the pop cycle.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_i);
            tag_tbl[vecs[i].idx] = vecs[i].hit ? vecs[i].tag : ~vecs[i].tag;
            avail_tbl[vecs[i].idx] = vecs[i].avail;
            cm_valid_i = 2'b01;
            cm_index_i = {8'h00, vecs[i].idx};
            cm_tag_i = {8'h00, vecs[i].tag};
            cm_pred_value_i = {8'h00, vecs[i].pred};
            cm_actual_value_i = {8'h00, vecs[i].act};
            @(posedge clk_i);
            #1 cm_valid_i = '0;
            @(posedge clk_i);
            #1 check($sformatf("vec%0d", i), obs(), upd_rec(vecs[i].idx, vecs[i].strb, vecs[i].etag, vecs[i].eval));
            @(posedge clk_i);
            #1 check($sformatf("vec%0d_one_cycle", i), obs(), '0);
        end

        // Back-to-back commits to the same index: one stall cycle between strobes.
        @(negedge clk_i);
        tag_tbl[3] = 8'h6C;
        cm_valid_i = 2'b11;
        cm_index_i = {8'd3, 8'd3};
        cm_tag_i = {8'h6C, 8'h6C};
        cm_pred_value_i = {8'd5, 8'd1};
        cm_actual_value_i = {8'd5, 8'd2};
        @(posedge clk_i);
        #1 cm_valid_i = '0;
        @(posedge clk_i);
        #1 check("haz_first", obs(), upd_rec(8'd3, S_HIT_BAD, 8'h00, 8'd2));
        @(posedge clk_i);
        #1 check("haz_stall", obs(), '0);
        check1("haz_busy", busy_o, 1'b1);
        @(posedge clk_i);
        #1 check("haz_second", obs(), upd_rec(8'd3, S_HIT_OK, 8'h00, 8'h00));

        // Sixteen failures -> sweep; fill the FIFO during the sweep.
        do_reset();
        exp_q.delete();
        ref_fail = 0;
        for (int i = 100; i < 116; i++) begin
            tag_tbl[i] = 8'h00;
            avail_tbl[i] = 1'b0;
        end
        for (int i = 200; i < 208; i++) tag_tbl[i] = 8'h77;
        mon_en = 1'b1;
        for (int k = 0; k < 8; k++)
            push_req(2'b11, {8'(101 + 2 * k), 8'(100 + 2 * k)}, {8'h5A, 8'h5A}, {8'd1, 8'd1}, {8'd1, 8'd1});
        t = 0;
        while (!ud_rst_use_o[1] && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        check1("sweep_started", ud_rst_use_o[1], 1'b1);
        for (int k = 0; k < 4; k++) begin
            ix = {8'(201 + 2 * k), 8'(200 + 2 * k)};
            pr = {8'(2 * k + 1), 8'(2 * k)};
            ac = {8'(2 * k + 2), 8'(2 * k)};
            push_req(2'b11, ix, {8'h77, 8'h77}, pr, ac);
        end
        check1("ready_low_full", cm_ready_o, 1'b0);
        @(negedge clk_i);
        cm_valid_i = 2'b11;
        cm_index_i = {8'd251, 8'd250};
        cm_tag_i = {8'h77, 8'h77};
        cm_pred_value_i = '0;
        cm_actual_value_i = '0;
        repeat (3) @(negedge clk_i);
        check1("ready_held_low", cm_ready_o, 1'b0);
        cm_valid_i = '0;
        drain(800);
        push_req(2'b01, {8'h00, 8'd102}, {8'h00, 8'h5A}, '0, '0);
        drain(100);
        mon_en = 1'b0;

        // Reset while the sweep is at base 64.
        for (int k = 0; k < 8; k++)
            push_req(2'b11, {8'(101 + 2 * k), 8'(100 + 2 * k)}, {8'h5A, 8'h5A}, {8'd1, 8'd1}, {8'd1, 8'd1});
        t = 0;
        while (!(ud_rst_use_o[0] && ud_index_o[0] == 8'd64) && t < 300) begin
            @(negedge clk_i);
            t++;
        end
        check("sweep_base64_seen", {54'h0, ud_index_o[0]}, 62'd64);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 check("rst_mid_outputs", obs(), '0);
        check1("rst_mid_busy", busy_o, 1'b0);
        check1("rst_mid_ready", cm_ready_o, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b0;
        stray = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (any_strobe() || busy_o) stray++;
        end
        check("no_activity_after_reset", OW'(stray), '0);
        exp_q.delete();
        ref_fail = 0;

        // Randomized traffic over a small index range to provoke hazards and sweeps.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            tag_tbl[i] = ($urandom_range(0, 1) == 1) ? 8'hA1 : 8'hA0;
            avail_tbl[i] = 1'($urandom_range(0, 1));
        end
        mon_en = 1'b1;
        for (int it = 0; it < 160; it++) begin
            @(negedge clk_i);
            for (int l = 0; l < NP; l++) begin
                ix[l] = 8'($urandom_range(0, 15));
                tg[l] = 8'hA0 | 8'($urandom_range(0, 1));
                pr[l] = 8'($urandom_range(0, 3));
                ac[l] = 8'($urandom_range(0, 3));
            end
            cm_valid_i = 2'($urandom_range(0, 3));
            cm_index_i = ix;
            cm_tag_i = tg;
            cm_pred_value_i = pr;
            cm_actual_value_i = ac;
            if (cm_ready_o)
                for (int l = 0; l < NP; l++)
                    if (cm_valid_i[l]) model_commit(ix[l], tg[l], pr[l], ac[l]);
            @(posedge clk_i);
            #1 cm_valid_i = '0;
        end
        drain(4000);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
